mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-port memory model that answers one processor request at a time.
// A request seen in IDLE is captured, held for WAIT_STATES extra cycles,
// performed on the access edge, and acknowledged by a one-cycle mem_ready
// pulse. Out-of-range and read+write-conflict accesses complete with normal
// latency but raise err. Requests arriving while busy are ignored and set the
// sticky drop flag.
//
// Handshake: a request is taken on any posedge where state is IDLE and
// MemRead or MemWrite is high; there is no request-side ready. The requester
// must treat mem_busy as "not accepting" and wait for the mem_ready pulse,
// which fires exactly once per accepted request.
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   MemRead      read request, sampled in IDLE
//   MemWrite     write request, sampled in IDLE
//   addr[15:0]   word address, captured with the request
//   wdata[15:0]  write data, captured with the request
//   rdata[15:0]  registered read data, held until the next completed read
//   mem_ready    one-cycle completion pulse
//   mem_busy     high whenever the FSM is not IDLE
//   err          one-cycle fault pulse, coincident with mem_ready
//   drop         sticky: a request arrived while busy
//   dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH       = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        err,
    output logic        drop,
    output logic [1:0]  dbg_state_o
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        op_rd_q, op_rd_d;
    logic        op_wr_q, op_wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;

    // Array is intentionally outside reset so contents survive it.
    logic [15:0] mem_q [DEPTH];

    logic          req;
    logic          access;
    logic          oor;
    logic          conflict;
    logic [AW-1:0] idx;

    assign req      = MemRead | MemWrite;
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign oor      = {16'd0, addr_q} >= DEPTH_U;
    assign conflict = op_rd_q & op_wr_q;
    assign idx      = addr_q[AW-1:0];

    // State register and captured request / output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            rdata_q <= 16'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_rd_q <= op_rd_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values. ready and err are computed on the
    // access edge so their registered versions line up with DONE.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_rd_d = op_rd_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        drop_d  = drop_q | (req && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = WS;
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_rd_d = MemRead;
                    op_wr_d = MemWrite;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    if (conflict) begin
                        err_d = 1'b1;
                    end else if (oor) begin
                        err_d = 1'b1;
                        if (op_rd_q) rdata_d = 16'h0000;
                    end else if (op_rd_q) begin
                        rdata_d = mem_q[idx];
                    end
                end
            end
            default: ;
        endcase
    end

    // Array write; gated by state_q so an aborted access never lands.
    always_ff @(posedge clk) begin
        if (access && op_wr_q && !op_rd_q && !oor) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign rdata       = rdata_q;
    assign mem_ready   = ready_q;
    assign err         = err_q;
    assign drop        = drop_q;
    assign mem_busy    = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] wdata = 16'd0;

  logic [15:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b, drop_a, drop_b;
  logic [1:0]  state_a, state_b;

  int total = 0;
  int bad = 0;

  logic [15:0] model [256];
  logic [15:0] exp_rd = 16'd0;
  logic        exp_drop = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(WS_A), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .mem_ready(ready_a),
    .mem_busy(busy_a), .err(err_a), .drop(drop_a), .dbg_state_o(state_a)
  );

  mem_responder #(.WAIT_STATES(WS_B), .DEPTH(256)) dut_b (
    .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .mem_ready(ready_b),
    .mem_busy(busy_b), .err(err_b), .drop(drop_b), .dbg_state_o(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction, applied to both instances at once. When hold is set
  // the request stays high (with a different addr) through the next edge.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic hold, input logic exp_err,
                     input logic [15:0] exp_rdata, input logic exp_drp, input string tag);
    int lat_a, lat_b, pulses_a, pulses_b;
    logic err_sa, err_sb;
    logic [15:0] rd_sa, rd_sb;
    lat_a = 0; lat_b = 0; pulses_a = 0; pulses_b = 0;
    err_sa = 1'b0; err_sb = 1'b0; rd_sa = 16'd0; rd_sb = 16'd0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    if (hold) begin
      addr = a + 16'd1;
    end else begin
      mem_read = 1'b0; mem_write = 1'b0;
      addr = 16'($urandom); wdata = 16'($urandom);
    end
    check({tag, ":busy_a"}, 32'(busy_a), 32'd1);
    check({tag, ":state_a"}, 32'(state_a), 32'd1);
    check({tag, ":state_b"}, 32'(state_b), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1 && hold) begin
        mem_read = 1'b0; mem_write = 1'b0;
        addr = 16'($urandom); wdata = 16'($urandom);
      end
      if (ready_a) begin
        pulses_a++;
        if (lat_a == 0) begin lat_a = k; err_sa = err_a; rd_sa = rdata_a; end
      end
      if (ready_b) begin
        pulses_b++;
        if (lat_b == 0) begin lat_b = k; err_sb = err_b; rd_sb = rdata_b; end
      end
    end
    check({tag, ":lat_a"}, 32'(lat_a), 32'(WS_A + 1));
    check({tag, ":lat_b"}, 32'(lat_b), 32'(WS_B + 1));
    check({tag, ":pulses_a"}, 32'(pulses_a), 32'd1);
    check({tag, ":pulses_b"}, 32'(pulses_b), 32'd1);
    check({tag, ":err_a"}, 32'(err_sa), 32'(exp_err));
    check({tag, ":err_b"}, 32'(err_sb), 32'(exp_err));
    check({tag, ":rdata_a"}, 32'(rd_sa), 32'(exp_rdata));
    check({tag, ":rdata_b"}, 32'(rd_sb), 32'(exp_rdata));
    check({tag, ":rdata_hold_a"}, 32'(rdata_a), 32'(exp_rdata));
    check({tag, ":idle_a"}, {busy_a, ready_a, err_a, busy_b, ready_b, err_b}, 32'd0);
    check({tag, ":drop_a"}, 32'(drop_a), 32'(exp_drp));
    check({tag, ":drop_b"}, 32'(drop_b), 32'(exp_drp));
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d, input string tag);
    logic oor;
    oor = (a >= 16'd256);
    txn(1'b0, 1'b1, a, d, 1'b0, oor, exp_rd, exp_drop, tag);
    if (!oor) model[a[7:0]] = d;
  endtask

  task automatic rd_word(input logic [15:0] a, input string tag);
    logic oor;
    oor = (a >= 16'd256);
    exp_rd = oor ? 16'h0000 : model[a[7:0]];
    txn(1'b1, 1'b0, a, 16'd0, 1'b0, oor, exp_rd, exp_drop, tag);
  endtask

  initial begin
    logic [7:0] b;

    // reset state
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", {rdata_a, ready_a, busy_a, err_a, drop_a, state_a}, 32'd0);
    check("reset_b", {rdata_b, ready_b, busy_b, err_b, drop_b, state_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // fill the whole array with a known pattern
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      wr_word({8'd0, b}, {b, ~b}, "fill");
    end
    wr_word(16'h0003, 16'h5555, "pre3");

    // write then read; a write must leave rdata alone
    rd_word(16'h0007, "rd7");
    wr_word(16'h0005, 16'hBEEF, "wr5");
    rd_word(16'h0005, "rd5");

    // latency on the zero-wait instance is checked on every transaction
    wr_word(16'h0010, 16'h1234, "wr10");
    rd_word(16'h0010, "rd10");

    // out of range
    rd_word(16'h0100, "rd_oor");
    wr_word(16'h0200, 16'hFFFF, "wr_oor");

    // read+write conflict
    rd_word(16'h0002, "rd2");
    txn(1'b1, 1'b1, 16'h0001, 16'hDEAD, 1'b0, 1'b1, exp_rd, exp_drop, "conflict");
    rd_word(16'h0001, "rd1_after_conflict");

    // busy drop: request held into the cycle after capture
    check("drop_clear_a", 32'(drop_a), 32'd0);
    exp_drop = 1'b1;
    exp_rd = model[5];
    txn(1'b1, 1'b0, 16'h0005, 16'd0, 1'b1, 1'b0, exp_rd, 1'b1, "drop");
    rd_word(16'h0007, "drop_sticky");

    // reset during WAIT aborts the pending write
    @(negedge clk);
    mem_write = 1'b1; addr = 16'h0003; wdata = 16'hAAAA;
    @(posedge clk); #1;
    mem_write = 1'b0;
    check("rstmid:state_a", 32'(state_a), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid:zero_a", {rdata_a, ready_a, busy_a, err_a, drop_a, state_a}, 32'd0);
    check("rstmid:zero_b", {rdata_b, ready_b, busy_b, err_b, drop_b, state_b}, 32'd0);
    exp_rd = 16'd0;
    exp_drop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rstmid:no_ready", {ready_a, ready_b}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    rd_word(16'h0003, "rd3_after_rst");

    // full sweep: nothing disturbed by the discarded writes
    for (int i = 0; i < 256; i++) begin
      rd_word(16'(i), "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
